// File: rtl/axi_master_rd.sv
// AXI4 read master: one local request -> one INCR AR burst, R beats buffered.
// Optional watchdog enabled by defining AXI_RD_TIMEOUT_EN.
module axi_master_rd #(
  parameter int ID_WIDTH       = 1,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 512,
  parameter int ARUSER_WIDTH   = 8,
  parameter int FIFO_DEPTH     = 256,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [31:0]             i_snap_context,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [3:0]              m_axi_arcache,
  output logic                    m_axi_arlock,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    lcl_ibusy,
  input  logic                    lcl_istart,
  input  logic [ADDR_WIDTH-1:0]   lcl_iaddr,
  input  logic [7:0]              lcl_inum,
  input  logic                    lcl_ordy,
  output logic                    lcl_dv,
  output logic [DATA_WIDTH-1:0]   lcl_dout,
  output logic                    lcl_olast,
  output logic [5:0]              status,
  output logic [3:0]              error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = DATA_WIDTH + 1;
  localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] HIGH = (AW+1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t          state, state_n;
  logic [7:0]      cnt;
  logic [AW:0]     wptr, rptr, count, count_n;
  logic [FW-1:0]   mem [FIFO_DEPTH];
  logic            len_err, rdovfl, len_eff;
  logic [1:0]      rd_error;
  logic            accept, push, pop, flush;
  logic            empty, full, len_hit;
  logic            unused_ok;

  assign m_axi_arid     = '0;
  assign m_axi_arsize   = SIZE;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arcache  = 4'd3;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arprot   = 3'd0;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;
  assign m_axi_aruser   = i_snap_context[ARUSER_WIDTH-1:0];
  assign unused_ok      = ^{m_axi_rid, i_snap_context};

  assign lcl_ibusy = (state != IDLE);
  assign empty     = (count == '0);
  assign full      = (count == DEPTH);
  assign flush     = clear & (state == IDLE);
  assign accept    = (state == DATA) & m_axi_rvalid
                   & m_axi_rready;
  assign push      = accept & ~full;
  assign pop       = ~empty & lcl_ordy & ~flush;
  assign count_n   = flush ? '0
                   : count + {{AW{1'b0}}, push}
                           - {{AW{1'b0}}, pop};

  // Length violations: early/late rlast, or data outside the data phase.
  assign len_hit = (accept & m_axi_rlast & (cnt != 8'd0))
                 | (accept & ~m_axi_rlast & (cnt == 8'd0))
                 | (m_axi_rvalid & (state == IDLE))
                 | (m_axi_rvalid & (state == ADDR));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (lcl_istart) state_n = ADDR;
      ADDR:  if (m_axi_arvalid && m_axi_arready) state_n = DATA;
      DATA:  if (accept && m_axi_rlast) state_n = DRAIN;
      DRAIN: if (lcl_dv && lcl_olast) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
      cnt           <= '0;
    end else begin
      if (state == IDLE && lcl_istart) begin
        m_axi_araddr  <= lcl_iaddr;
        m_axi_arlen   <= lcl_inum - 8'd1;
        cnt           <= lcl_inum - 8'd1;
        m_axi_arvalid <= 1'b1;
      end
      if (state == ADDR && m_axi_arready)
        m_axi_arvalid <= 1'b0;
      if (accept && cnt != 8'd0)
        cnt <= cnt - 8'd1;
    end
  end

  // Looking at next occupancy keeps one spare slot behind registered rready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_axi_rready <= 1'b0;
    else        m_axi_rready <= (state_n == DATA)
                              && (count_n <= HIGH);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {m_axi_rdata, m_axi_rlast};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      lcl_dv    <= 1'b0;
      lcl_dout  <= '0;
      lcl_olast <= 1'b0;
    end else begin
      count  <= count_n;
      lcl_dv <= pop;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
      end
      if (pop) begin
        lcl_dout  <= mem[rptr[AW-1:0]][FW-1:1];
        lcl_olast <= mem[rptr[AW-1:0]][0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_err  <= 1'b0;
      rdovfl   <= 1'b0;
      rd_error <= 2'b00;
    end else if (clear) begin
      len_err  <= 1'b0;
      rdovfl   <= 1'b0;
      rd_error <= 2'b00;
    end else begin
      if (len_hit) len_err <= 1'b1;
      if (accept && full) rdovfl <= 1'b1;
      if (accept && m_axi_rresp != 2'b00)
        rd_error <= m_axi_rresp;
    end
  end

`ifdef AXI_RD_TIMEOUT_EN
  logic [31:0] wd;
  logic        to_flag;
  logic        hs, watch;

  assign hs    = (m_axi_arvalid & m_axi_arready)
               | (m_axi_rvalid & m_axi_rready);
  assign watch = (state == ADDR) | (state == DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd      <= '0;
      to_flag <= 1'b0;
    end else begin
      if (!watch || hs)
        wd <= '0;
      else if (wd < 32'(TIMEOUT_CYCLES))
        wd <= wd + 32'd1;
      if (clear)
        to_flag <= 1'b0;
      else if (watch && !hs
               && wd == 32'(TIMEOUT_CYCLES - 1))
        to_flag <= 1'b1;
    end
  end

  assign len_eff = len_err | to_flag;
`else
  assign len_eff = len_err;
`endif

  assign error  = {len_eff, rdovfl, rd_error};
  assign status = {empty, full, len_eff, rdovfl, rd_error};

endmodule

// File: tb/tb_axi_master_rd.sv
// Directed bench for axi_master_rd: small FIFO, 32-bit data, short watchdog.
module tb_axi_master_rd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [31:0] ctx;
  logic [0:0]  arid;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arlock;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic [3:0]  arregion;
  logic [7:0]  aruser;
  logic        arvalid;
  logic        arready;
  logic [0:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        ibusy;
  logic        istart;
  logic [63:0] iaddr;
  logic [7:0]  inum;
  logic        ordy;
  logic        dv;
  logic [31:0] dout;
  logic        olast;
  logic [5:0]  status;
  logic [3:0]  error;

  int checks = 0;
  int errors = 0;
  logic [32:0] q[$];

  always #5 clk = ~clk;

  axi_master_rd #(
    .ID_WIDTH(1), .ADDR_WIDTH(64), .DATA_WIDTH(32),
    .ARUSER_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .i_snap_context(ctx),
    .m_axi_arid(arid), .m_axi_araddr(araddr),
    .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arcache(arcache),
    .m_axi_arlock(arlock), .m_axi_arprot(arprot),
    .m_axi_arqos(arqos), .m_axi_arregion(arregion),
    .m_axi_aruser(aruser), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rid(rid),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready),
    .lcl_ibusy(ibusy), .lcl_istart(istart),
    .lcl_iaddr(iaddr), .lcl_inum(inum),
    .lcl_ordy(ordy), .lcl_dv(dv), .lcl_dout(dout),
    .lcl_olast(olast), .status(status), .error(error)
  );

  always @(negedge clk)
    if (dv) q.push_back({olast, dout});

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [63:0] a,
                           input logic [7:0] n);
    iaddr  = a;
    inum   = n;
    istart = 1'b1;
    @(negedge clk);
    istart = 1'b0;
  endtask

  task automatic ar_pulse();
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
  endtask

  task automatic r_burst(input int n, input int last_at,
                         input int err_at,
                         input logic [1:0] resp,
                         input logic [31:0] base);
    logic acc;
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1;
      rdata  = base + i;
      rlast  = (i == last_at);
      rresp  = (i == err_at) ? resp : 2'b00;
      acc    = 1'b0;
      for (int k = 0; k < 200 && !acc; k++) begin
        acc = rready;
        @(negedge clk);
      end
      if (!acc) begin
        chk("r_accept", 64'(acc), 64'd1);
        break;
      end
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && ibusy; k++)
      @(negedge clk);
    if (ibusy) chk("idle_timeout", 64'(ibusy), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_beats(input int n,
                             input logic [31:0] base);
    int bad = 0;
    chk("beat_count", 64'(q.size()), 64'(n));
    for (int i = 0; i < q.size(); i++) begin
      if (q[i][31:0] !== base + i) bad++;
      if (q[i][32] !== (i == n - 1)) bad++;
    end
    chk("beat_data", 64'(bad), 64'd0);
    q.delete();
  endtask

  initial begin
    logic exp_to;
`ifdef AXI_RD_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    rst_n = 1'b0; clear = 1'b0; ctx = 32'hCAFE_00A5;
    arready = 1'b0; rid = 1'b0; rdata = '0;
    rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    istart = 1'b0; iaddr = '0; inum = '0; ordy = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_araddr", araddr, 64'd0);
    chk("rst_arlen", 64'(arlen), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_dv", 64'(dv), 64'd0);
    chk("rst_busy", 64'(ibusy), 64'd0);
    chk("rst_status", 64'(status), 64'h20);
    chk("rst_error", 64'(error), 64'd0);

    // basic read plus an ignored start while busy
    start_req(64'h1000, 8'd4);
    chk("b_arvalid", 64'(arvalid), 64'd1);
    chk("b_araddr", araddr, 64'h1000);
    chk("b_arlen", 64'(arlen), 64'd3);
    chk("b_busy", 64'(ibusy), 64'd1);
    chk("b_aruser", 64'(aruser), 64'hA5);
    chk("b_arconst",
        64'({arid, arsize, arburst, arcache, arlock,
             arprot, arqos, arregion}),
        64'({1'b0, 3'd2, 2'd1, 4'd3, 1'b0,
             3'd0, 4'd0, 4'd0}));
    start_req(64'h2000, 8'd9);
    chk("busy_araddr", araddr, 64'h1000);
    chk("busy_arlen", 64'(arlen), 64'd3);
    ar_pulse();
    chk("b_ar_drop", 64'(arvalid), 64'd0);
    chk("b_rready", 64'(rready), 64'd1);
    r_burst(4, 3, -1, 2'b00, 32'hA0);
    wait_idle();
    check_beats(4, 32'hA0);
    chk("b_error", 64'(error), 64'd0);
    chk("b_no_2nd_ar", 64'(arvalid), 64'd0);
    chk("b_araddr_end", araddr, 64'h1000);

    // 256-beat burst
    start_req(64'h8000, 8'd0);
    chk("f_arlen", 64'(arlen), 64'd255);
    ar_pulse();
    r_burst(256, 255, -1, 2'b00, 32'h0);
    wait_idle();
    check_beats(256, 32'h0);
    chk("f_busy", 64'(ibusy), 64'd0);

    // consumer stalls; rready must back off
    ordy = 1'b0;
    start_req(64'h3000, 8'd16);
    ar_pulse();
    fork
      r_burst(16, 15, -1, 2'b00, 32'h300);
      begin
        repeat (20) @(negedge clk);
        chk("bp_rready", 64'(rready), 64'd0);
        chk("bp_occ3", 64'(dut.count >= 3), 64'd1);
        chk("bp_ovfl", 64'(error[2]), 64'd0);
        ordy = 1'b1;
      end
    join
    wait_idle();
    check_beats(16, 32'h300);
    chk("bp_error", 64'(error), 64'd0);

    // SLVERR on beat 2, then clear
    start_req(64'h4000, 8'd4);
    ar_pulse();
    r_burst(4, 3, 1, 2'b10, 32'h40);
    wait_idle();
    check_beats(4, 32'h40);
    chk("resp_err", 64'(error), 64'h2);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("resp_clr", 64'(error), 64'd0);

    // early rlast on beat 3 of 4
    start_req(64'h5000, 8'd4);
    ar_pulse();
    r_burst(3, 2, -1, 2'b00, 32'h50);
    wait_idle();
    check_beats(3, 32'h50);
    chk("len_err", 64'(error), 64'h8);
    chk("len_status", 64'(status), 64'h28);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("len_clr", 64'(error), 64'd0);

    // stalled AR: watchdog only when compiled in
    start_req(64'h6000, 8'd1);
    repeat (9) @(negedge clk);
    chk("to_early", 64'(error), 64'd0);
    repeat (10) @(negedge clk);
    chk("to_flag", 64'(error[3]), 64'(exp_to));
    chk("to_arvalid", 64'(arvalid), 64'd1);
    ar_pulse();
    r_burst(1, 0, -1, 2'b00, 32'h60);
    wait_idle();
    check_beats(1, 32'h60);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("to_clr", 64'(error), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_master_rd.md
Name:
axi_master_rd

Overview:
- AXI4 read master: turns one local read request (address + beat count) into a single INCR AR burst.
- Buffers the returned R beats in an internal FIFO and delivers them to the local consumer under lcl_ordy backpressure.
- Sibling of the existing write-channel master; shares its context/AxUSER scheme and its status/error format.

Parameters:
- ID_WIDTH, 1, width of arid/rid.
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 512, data width; arsize = log2(DATA_WIDTH/8), i.e. 3'd6 at the default.
- ARUSER_WIDTH, 8, aruser width, taken from i_snap_context LSBs.
- FIFO_DEPTH, 256, read-data FIFO depth in entries; power of 2, at least 4.
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with AXI_RD_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous; clears sticky errors and flushes the FIFO when idle
- i_snap_context  in  32  context; bits [ARUSER_WIDTH-1:0] drive m_axi_aruser
- m_axi_arid  out  ID_WIDTH  constant 0
- m_axi_araddr  out  ADDR_WIDTH  burst address (registered)
- m_axi_arlen  out  8  beats-1 (registered)
- m_axi_arsize/arburst/arcache/arlock/arprot/arqos/arregion  out  3/2/4/1/3/4/4  constants: log2(DATA_WIDTH/8), INCR=1, 4'd3, 0, 0, 0, 0
- m_axi_aruser  out  ARUSER_WIDTH  context
- m_axi_arvalid  out  1  address valid
- m_axi_arready  in  1
- m_axi_rid  in  ID_WIDTH  ignored
- m_axi_rdata  in  DATA_WIDTH
- m_axi_rresp  in  2
- m_axi_rlast  in  1
- m_axi_rvalid  in  1
- m_axi_rready  out  1
- lcl_ibusy  out  1  request in progress
- lcl_istart  in  1  one-cycle request strobe
- lcl_iaddr  in  ADDR_WIDTH
- lcl_inum  in  8  beat count; 0 means 256
- lcl_ordy  in  1  consumer can accept a beat
- lcl_dv  out  1  lcl_dout valid
- lcl_dout  out  DATA_WIDTH
- lcl_olast  out  1  with the final beat of the burst
- status  out  6  {fifo_empty, fifo_full, len_err, rdovfl, rd_error[1:0]}
- error  out  4  {len_err, rdovfl, rd_error[1:0]}

Behaviour:
- Reset values:
  - All registered outputs 0: arvalid, araddr, arlen, rready, lcl_dv, lcl_dout, lcl_olast.
  - FSM in IDLE; FIFO empty; sticky errors 0.
- FSM states and transitions:
  - IDLE: lcl_istart -> ADDR. Latch araddr=lcl_iaddr and arlen=lcl_inum-1 (8-bit wrap, so inum 0 -> 255). Load beat counter = arlen. Assert arvalid next cycle.
  - ADDR: hold arvalid, araddr and arlen stable until arready is sampled high; then drop arvalid -> DATA.
  - DATA: each rvalid&rready pushes {rdata, rlast} into the FIFO and decrements the beat counter. The accepted beat with rlast -> DRAIN.
  - DRAIN: when the beat flagged lcl_olast is delivered -> IDLE.
- lcl_ibusy = (state != IDLE), combinational from the state register.
- lcl_istart while busy is ignored; no state or register change.
- m_axi_rready:
  - Registered; 1 only in DATA when FIFO free entries >= 2 (margin for the registered rready).
  - 0 in IDLE, ADDR and DRAIN.
- Local output:
  - Pop when FIFO non-empty and lcl_ordy=1.
  - lcl_dv=1 one cycle after the pop, with lcl_dout and lcl_olast registered from the FIFO entry.
  - lcl_dv=0 otherwise; lcl_dout holds its last value.
  - Latency from AXI accept to lcl_dv is 2 cycles minimum.
- Simultaneous push and pop: allowed; occupancy unchanged.
- len_err (sticky): set when
  - rlast arrives with beat counter != 0, or
  - a beat with counter==0 arrives without rlast (FSM still waits for rlast), or
  - rvalid is seen in IDLE or ADDR (beat is not accepted).
- rd_error (sticky): captures the latest rresp != 0 on any accepted beat.
- rdovfl (sticky): set on a push while the FIFO is full; the beat is dropped.
- clear:
  - Zeroes len_err, rdovfl and rd_error (and timeout) every cycle it is asserted.
  - Also flushes the FIFO only in IDLE.
  - Never aborts a transfer.
  - clear and an error event in the same cycle: clear wins.
- Reset mid-burst: asynchronous return to IDLE with everything cleared. AXI slave-side recovery is out of scope.

Optional Feature:
- Macro AXI_RD_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counts cycles in ADDR or DATA with no arready/rvalid handshake, restarting at 0 on each handshake.
  - Reaching TIMEOUT_CYCLES sets a sticky timeout flag; error[3] and status[3] become len_err|timeout.
  - No abort.
- Undefined: no counter; error[3] = len_err only.

Test Plan:
- Basic read: inum=4, addr=0x1000, arready after 2 cycles, lcl_ordy=1 -> arlen=3, araddr=0x1000, 4 lcl_dv beats in order, lcl_olast on beat 4, lcl_ibusy falls after beat 4, error=0.
- Full burst: inum=0 -> arlen=255; 256 beats delivered, then IDLE.
- Backpressure: FIFO_DEPTH=4, inum=16, lcl_ordy low for 20 cycles -> rready deasserts with occupancy >= 3, rdovfl=0, all 16 beats later delivered intact.
- Response/length errors:
  - rresp=2'b10 on beat 2 -> error[1:0]=2'b10.
  - rlast on beat 3 of inum=4 -> len_err=1.
  - clear pulse -> error=0.
- lcl_istart during busy with addr=0x2000 -> ignored; araddr stays 0x1000; no second AR.
- With AXI_RD_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready held low -> error[3]=1 at cycle 16 of ADDR; without the macro error stays 0.
